// File: rtl/bcd_to_bin_seq.sv
// rtl/bcd_to_bin_seq.sv - sequential packed-BCD to binary converter (optional BCD_TO_BIN_DIGIT_CHECK_EN)
// Reverse double-dabble: one bit per cycle, 4*DIGITS cycles per conversion.
module bcd_to_bin_seq #(
    parameter int DIGITS = 4,
    parameter int BIN_W  = 14
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [4*DIGITS-1:0]   in_bcd,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [BIN_W-1:0]      out_bin,
    output logic                  out_err
);
    localparam int W     = 4 * DIGITS;
    localparam int CNT_W = $clog2(W + 1);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t           state;
    logic [W-1:0]     bcd_q;
    logic [W-1:0]     bin_q;
    logic [CNT_W-1:0] cnt;
    logic [2*W-1:0]   nxt;
    logic             err_q;
    logic             bad_digit;

    // One iteration: shift {bcd,bin} right, then correct each BCD digit that reached >= 8.
    always_comb begin
        nxt = {bcd_q, bin_q} >> 1;
        for (int i = 0; i < DIGITS; i++) begin
            if (nxt[W+4*i +: 4] >= 4'd8)
                nxt[W+4*i +: 4] = nxt[W+4*i +: 4] - 4'd3;
        end
    end

`ifdef BCD_TO_BIN_DIGIT_CHECK_EN
    always_comb begin
        bad_digit = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            if (in_bcd[4*i +: 4] > 4'd9)
                bad_digit = 1'b1;
        end
    end
`else
    assign bad_digit = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            bcd_q     <= '0;
            bin_q     <= '0;
            cnt       <= '0;
            err_q     <= 1'b0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            out_bin   <= '0;
            out_err   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        bcd_q    <= in_bcd;
                        bin_q    <= '0;
                        cnt      <= CNT_W'(W);
                        err_q    <= bad_digit;
                        in_ready <= 1'b0;
                        state    <= SHIFT;
                    end
                end
                SHIFT: begin
                    bcd_q <= nxt[2*W-1:W];
                    bin_q <= nxt[W-1:0];
                    if (cnt != '0)
                        cnt <= cnt - CNT_W'(1);
                    if (cnt == CNT_W'(1)) begin
                        out_bin   <= err_q ? '0 : nxt[BIN_W-1:0];
                        out_err   <= err_q;
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state     <= IDLE;
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_bcd_to_bin_seq.sv
// tb/tb_bcd_to_bin_seq.sv - self-checking bench for bcd_to_bin_seq (default and 8-digit instances)
module tb_bcd_to_bin_seq;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid, out_ready;
    logic [15:0] in_bcd;
    logic        in_ready, out_valid, out_err;
    logic [13:0] out_bin;

    logic        in_valid8;
    logic [31:0] in_bcd8;
    logic        in_ready8, out_valid8, out_err8;
    logic [26:0] out_bin8;

    int passed = 0;
    int total  = 0;

    typedef struct {
        logic [31:0] bin;
        logic        err;
        logic        chk_bin;
    } exp_t;
    exp_t sb[$];

    typedef struct {
        logic [15:0] bcd;
        logic [13:0] bin;
        logic        err;
        logic        chk_bin;
    } vec_t;

    always #5 clk = ~clk;

    bcd_to_bin_seq dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_bcd(in_bcd),
        .out_valid(out_valid), .out_ready(out_ready), .out_bin(out_bin), .out_err(out_err)
    );

    bcd_to_bin_seq #(.DIGITS(8), .BIN_W(27)) dut8 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid8), .in_ready(in_ready8), .in_bcd(in_bcd8),
        .out_valid(out_valid8), .out_ready(1'b1), .out_bin(out_bin8), .out_err(out_err8)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Accept one request, check latency and busy in_ready, compare against the scoreboard head.
    task automatic do_conv(input logic [15:0] bcd, input logic [13:0] bin, input logic err,
                           input logic chk_bin);
        int   lat;
        logic rdy_seen;
        exp_t e;
        check("in_ready_before_accept", in_ready, 1'b1);
        in_valid = 1'b1;
        in_bcd   = bcd;
        step();
        sb.push_back('{bin: {18'd0, bin}, err: err, chk_bin: chk_bin});
        in_valid = 1'b0;
        in_bcd   = ~bcd;
        lat      = 0;
        rdy_seen = 1'b0;
        while (!out_valid && lat < 200) begin
            if (in_ready) rdy_seen = 1'b1;
            step();
            lat++;
        end
        check("latency", lat, 16);
        check("in_ready_low_while_busy", rdy_seen, 1'b0);
        check("in_ready_low_in_done", in_ready, 1'b0);
        e = sb.pop_front();
        if (e.chk_bin) check("out_bin", {18'd0, out_bin}, e.bin);
        check("out_err", out_err, e.err);
    endtask

    task automatic finish_out();
        step();
        check("out_valid_drops", out_valid, 1'b0);
        check("in_ready_returns", in_ready, 1'b1);
    endtask

    initial begin
        vec_t vecs[$];
        vecs.push_back('{16'h1234, 14'd1234, 1'b0, 1'b1});
        vecs.push_back('{16'h9999, 14'd9999, 1'b0, 1'b1});
        vecs.push_back('{16'h0000, 14'd0,    1'b0, 1'b1});
        vecs.push_back('{16'h0001, 14'd1,    1'b0, 1'b1});
        vecs.push_back('{16'h5000, 14'd5000, 1'b0, 1'b1});
        vecs.push_back('{16'h0909, 14'd909,  1'b0, 1'b1});
        vecs.push_back('{16'h8765, 14'd8765, 1'b0, 1'b1});
`ifdef BCD_TO_BIN_DIGIT_CHECK_EN
        vecs.push_back('{16'h12A4, 14'd0,    1'b1, 1'b1});
`else
        vecs.push_back('{16'h12A4, 14'd0,    1'b0, 1'b0});
`endif
        vecs.push_back('{16'h0009, 14'd9,    1'b0, 1'b1});

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_bcd    = '0;
        out_ready = 1'b1;
        in_valid8 = 1'b0;
        in_bcd8   = '0;
        step();
        step();
        check("rst_in_ready", in_ready, 1'b1);
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_out_bin", out_bin, 14'd0);
        check("rst_out_err", out_err, 1'b0);
        rst_n = 1'b1;

        foreach (vecs[i]) begin
            do_conv(vecs[i].bcd, vecs[i].bin, vecs[i].err, vecs[i].chk_bin);
            finish_out();
        end

        // Consumer stall: result must hold, new requests must be ignored.
        out_ready = 1'b0;
        do_conv(16'h0567, 14'd567, 1'b0, 1'b1);
        for (int i = 0; i < 5; i++) begin
            in_bcd   = 16'h0111 * 16'(i + 1);
            in_valid = i[0];
            step();
            check("stall_out_valid", out_valid, 1'b1);
            check("stall_out_bin", out_bin, 14'd567);
            check("stall_in_ready", in_ready, 1'b0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        finish_out();
        step();
        step();
        check("no_second_accept", out_valid, 1'b0);

        // Reset during iteration 7 of SHIFT aborts the conversion.
        in_valid = 1'b1;
        in_bcd   = 16'h1234;
        step();
        in_valid = 1'b0;
        for (int i = 0; i < 6; i++) step();
        rst_n = 1'b0;
        #1;
        check("abort_out_valid", out_valid, 1'b0);
        check("abort_in_ready", in_ready, 1'b1);
        check("abort_out_bin", out_bin, 14'd0);
        step();
        rst_n = 1'b1;
        do_conv(16'h0042, 14'd42, 1'b0, 1'b1);
        finish_out();

        // Eight-digit instance: full-scale value, 32-cycle latency.
        begin
            int   lat;
            exp_t e;
            check("d8_in_ready", in_ready8, 1'b1);
            in_valid8 = 1'b1;
            in_bcd8   = 32'h99999999;
            step();
            sb.push_back('{bin: 32'd99999999, err: 1'b0, chk_bin: 1'b1});
            in_valid8 = 1'b0;
            lat = 0;
            while (!out_valid8 && lat < 200) begin
                step();
                lat++;
            end
            check("d8_latency", lat, 32);
            e = sb.pop_front();
            check("d8_out_bin", {5'd0, out_bin8}, e.bin);
            check("d8_out_err", out_err8, e.err);
            step();
            check("d8_out_valid_drops", out_valid8, 1'b0);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
